// File: rtl/pipe_datapath_fetch_pkg.sv
// Shared types and helpers for the RV32I fetch stage: PC-source encodings,
// fetch FSM states, PC increment and next-PC select.
package pipe_datapath_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_ALU    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_KILL = 2'b10
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  // JALR targets are halfword-aligned by clearing bit 0; 2'b11 falls back to sequential.
  function automatic logic [XLEN-1:0] next_pc_mux(input logic [1:0]      sel,
                                                  input logic [XLEN-1:0] seq_pc,
                                                  input logic [XLEN-1:0] tgt_pc,
                                                  input logic [XLEN-1:0] alu_pc);
    logic [XLEN-1:0] res;
    case (sel)
      PCSRC_TARGET: res = tgt_pc;
      PCSRC_ALU:    res = {alu_pc[XLEN-1:1], 1'b0};
      default:      res = seq_pc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pipe_datapath_fetch_skid.sv
// One-entry holding buffer for an instruction response that arrives while
// Decode is stalled. Clear wins over push, push wins over pop.
module pipe_datapath_fetch_skid
  import pipe_datapath_fetch_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clear,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_full,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            full_r;
  logic [31:0]     instr_r;
  logic [XLEN-1:0] pc_r;

  // Single-entry storage with occupancy flag.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      full_r  <= 1'b0;
      instr_r <= 32'h0000_0000;
      pc_r    <= '0;
    end else if (i_clear) begin
      full_r <= 1'b0;
    end else if (i_push) begin
      full_r  <= 1'b1;
      instr_r <= i_instr;
      pc_r    <= i_pc;
    end else if (i_pop) begin
      full_r <= 1'b0;
    end
  end

  assign o_full  = full_r;
  assign o_instr = instr_r;
  assign o_pc    = pc_r;

endmodule

// File: rtl/pipe_datapath_fetch.sv
// Fetch stage: owns PCF, runs a single-outstanding req/gnt/rvalid fetch FSM,
// and drives the IF/ID register with Execute-stage redirect and Decode stall/flush.
module pipe_datapath_fetch
  import pipe_datapath_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [1:0]      i_PCSrcE,
  input  logic [XLEN-1:0] i_dp_PC_Plus_immE,
  input  logic [XLEN-1:0] i_dp_ALU,
  input  logic            i_StallD,
  input  logic            i_FlushD,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic [31:0]     o_InstrD,
  output logic [XLEN-1:0] o_PCD,
  output logic [XLEN-1:0] o_PCPlus4D,
  output logic            o_validD
);

  fetch_state_e    state_r;
  logic [XLEN-1:0] pcf_r;
  logic [XLEN-1:0] pc_pend_r;
  logic            valid_r;
  logic [31:0]     instr_r;
  logic [XLEN-1:0] pcd_r;
  logic [XLEN-1:0] pcp4_r;

  logic            redirect_s;
  logic [1:0]      pc_sel_s;
  logic [XLEN-1:0] pcf_next_s;
  logic            rvalid_wait_s;
  logic            push_s;
  logic            pop_s;
  logic            req_s;
  logic            hs_s;
  logic            skid_full_s;
  logic [31:0]     skid_instr_s;
  logic [XLEN-1:0] skid_pc_s;

  assign redirect_s    = (i_PCSrcE == PCSRC_TARGET) || (i_PCSrcE == PCSRC_ALU);
  assign pc_sel_s      = redirect_s ? i_PCSrcE : PCSRC_PLUS4;
  assign pcf_next_s    = next_pc_mux(pc_sel_s, pc_plus4(pcf_r), i_dp_PC_Plus_immE, i_dp_ALU);
  assign rvalid_wait_s = (state_r == ST_WAIT) && i_imem_rvalid;
  assign push_s        = rvalid_wait_s && i_StallD && !redirect_s;
  assign pop_s         = skid_full_s && !redirect_s && !i_FlushD && !i_StallD;
  assign hs_s          = req_s && i_imem_gnt;

  // Request is blocked during reset, on redirect, while killing, and while the skid holds data.
  always_comb begin
    req_s = 1'b0;
    if (!i_rstn || redirect_s) begin
      req_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: req_s = !skid_full_s;
        ST_WAIT: req_s = i_imem_rvalid && !i_StallD && !skid_full_s;
        ST_KILL: req_s = 1'b0;
        default: req_s = 1'b0;
      endcase
    end
  end

  // Fetch FSM together with PCF and the tag of the outstanding request.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r   <= ST_IDLE;
      pcf_r     <= RESET_PC;
      pc_pend_r <= '0;
    end else begin
      if (redirect_s || hs_s) begin
        pcf_r <= pcf_next_s;
      end
      if (hs_s) begin
        pc_pend_r <= pcf_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (hs_s) state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (redirect_s) begin
            state_r <= i_imem_rvalid ? ST_IDLE : ST_KILL;
          end else if (i_imem_rvalid) begin
            state_r <= hs_s ? ST_WAIT : ST_IDLE;
          end
        end
        ST_KILL: begin
          // The killed response always returns to IDLE so a redirect here cannot strand the FSM.
          if (i_imem_rvalid) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // IF/ID register: redirect > flush > stall > skid > direct response > bubble.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_r <= 1'b0;
      instr_r <= NOP_INSTR;
      pcd_r   <= '0;
      pcp4_r  <= '0;
    end else if (redirect_s || i_FlushD) begin
      valid_r <= 1'b0;
      instr_r <= NOP_INSTR;
    end else if (i_StallD) begin
      valid_r <= valid_r;
    end else if (skid_full_s) begin
      valid_r <= 1'b1;
      instr_r <= skid_instr_s;
      pcd_r   <= skid_pc_s;
      pcp4_r  <= pc_plus4(skid_pc_s);
    end else if (rvalid_wait_s) begin
      valid_r <= 1'b1;
      instr_r <= i_imem_rdata;
      pcd_r   <= pc_pend_r;
      pcp4_r  <= pc_plus4(pc_pend_r);
    end else begin
      valid_r <= 1'b0;
      instr_r <= NOP_INSTR;
    end
  end

  pipe_datapath_fetch_skid u_skid (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (push_s),
    .i_pop   (pop_s),
    .i_clear (redirect_s),
    .i_instr (i_imem_rdata),
    .i_pc    (pc_pend_r),
    .o_full  (skid_full_s),
    .o_instr (skid_instr_s),
    .o_pc    (skid_pc_s)
  );

  assign o_imem_req  = req_s;
  assign o_imem_addr = pcf_r;
  assign o_InstrD    = instr_r;
  assign o_PCD       = pcd_r;
  assign o_PCPlus4D  = pcp4_r;
  assign o_validD    = valid_r;

endmodule

// File: tb/tb_pipe_datapath_fetch.sv
// Bench for pipe_datapath_fetch: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then a randomised soak.
module tb_pipe_datapath_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pcsrc = 2'b00;
  logic [31:0] imm = 32'h0;
  logic [31:0] alu = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic [31:0] rdata_a = 32'h0;
  logic [31:0] rdata_b = 32'h0;
  int          lat = 1;

  logic        a_req, b_req, a_valid, b_valid;
  logic [31:0] a_addr, b_addr, a_instr, b_instr, a_pcd, b_pcd, a_pcp4, b_pcp4;

  int checks = 0;
  int errors = 0;

  // Model state (written only by the model process)
  logic [31:0] m_pc = 32'h0;
  logic        m_out = 1'b0;
  logic        m_dead = 1'b0;
  logic [31:0] m_out_pc = 32'h0;
  ent_t        q_skid[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pcd = 32'h0;
  logic [31:0] m_pcp4 = 32'h0;

  always #5 clk = ~clk;

  pipe_datapath_fetch dut_a (
    .i_clk(clk), .i_rstn(rst_n), .i_PCSrcE(pcsrc), .i_dp_PC_Plus_immE(imm),
    .i_dp_ALU(alu), .i_StallD(stall), .i_FlushD(flush), .o_imem_req(a_req),
    .o_imem_addr(a_addr), .i_imem_gnt(gnt), .i_imem_rvalid(rvalid),
    .i_imem_rdata(rdata_a), .o_InstrD(a_instr), .o_PCD(a_pcd),
    .o_PCPlus4D(a_pcp4), .o_validD(a_valid)
  );

  pipe_datapath_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .i_clk(clk), .i_rstn(rst_n), .i_PCSrcE(pcsrc), .i_dp_PC_Plus_immE(imm),
    .i_dp_ALU(alu), .i_StallD(stall), .i_FlushD(flush), .o_imem_req(b_req),
    .o_imem_addr(b_addr), .i_imem_gnt(gnt), .i_imem_rvalid(rvalid),
    .i_imem_rdata(rdata_b), .o_InstrD(b_instr), .o_PCD(b_pcd),
    .o_PCPlus4D(b_pcp4), .o_validD(b_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0AB0_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A fetch may be issued when nothing is in flight and the skid is empty,
  // or back-to-back with a live response that Decode consumes.
  function automatic logic exp_req_f();
    if (!rst_n) return 1'b0;
    if (pcsrc == 2'b01 || pcsrc == 2'b10) return 1'b0;
    if (!m_out) return (q_skid.size() == 0);
    if (m_dead) return 1'b0;
    return rvalid && !stall && (q_skid.size() == 0);
  endfunction

  // Instruction memory: answers each accepted request after lat cycles.
  initial begin
    logic        pend, rv_next, hs;
    int          cnt;
    logic [31:0] pa, pb;
    pend = 1'b0; cnt = 0; pa = 32'h0; pb = 32'h0;
    forever begin
      @(posedge clk);
      hs = rst_n && a_req && gnt;
      rv_next = 1'b0;
      if (!rst_n) pend = 1'b0;
      if (hs) begin
        pend = 1'b1; cnt = lat; pa = a_addr; pb = b_addr;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          rv_next = 1'b1;
          pend = 1'b0;
        end
      end
      #1;
      rvalid  = rv_next;
      rdata_a = rv_next ? mem_word(pa) : 32'hDEAD_BEEF;
      rdata_b = rv_next ? mem_word(pb) : 32'hDEAD_BEEF;
    end
  end

  // Behavioural model of the fetch stage, advanced once per clock edge.
  initial begin
    logic redir, hs, resp, deliv;
    ent_t e, s;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pc = 32'h0; m_out = 1'b0; m_dead = 1'b0; q_skid.delete();
        m_valid = 1'b0; m_instr = NOP; m_pcd = 32'h0; m_pcp4 = 32'h0;
      end else begin
        redir = (pcsrc == 2'b01) || (pcsrc == 2'b10);
        hs    = exp_req_f() && gnt;
        resp  = rvalid && m_out;
        if (redir) begin
          m_pc = (pcsrc == 2'b01) ? imm : (alu & 32'hFFFF_FFFE);
          q_skid.delete();
          m_valid = 1'b0; m_instr = NOP;
          if (resp) m_out = 1'b0;
          else if (m_out) m_dead = 1'b1;
        end else begin
          deliv   = resp && !m_dead;
          e.instr = mem_word(m_out_pc);
          e.pc    = m_out_pc;
          if (resp) begin m_out = 1'b0; m_dead = 1'b0; end
          if (flush) begin
            m_valid = 1'b0; m_instr = NOP;
          end else if (stall) begin
            m_valid = m_valid;
          end else if (q_skid.size() > 0) begin
            s = q_skid.pop_front();
            m_valid = 1'b1; m_instr = s.instr; m_pcd = s.pc; m_pcp4 = s.pc + 32'd4;
          end else if (deliv) begin
            m_valid = 1'b1; m_instr = e.instr; m_pcd = e.pc; m_pcp4 = e.pc + 32'd4;
          end else begin
            m_valid = 1'b0; m_instr = NOP;
          end
          if (deliv && stall) q_skid.push_back(e);
          if (hs) begin
            m_out = 1'b1; m_dead = 1'b0; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("req", {31'b0, a_req}, {31'b0, exp_req_f()});
      if (exp_req_f()) chk("addr", a_addr, m_pc);
      chk("validD", {31'b0, a_valid}, {31'b0, m_valid});
      chk("instrD", a_instr, m_instr);
      if (m_valid) begin
        chk("PCD", a_pcd, m_pcd);
        chk("PCPlus4D", a_pcp4, m_pcp4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_valid", {31'b0, a_valid}, 32'd0);
    chk("rst_instr", a_instr, 32'h0000_0013);
    chk("rst_pcd", a_pcd, 32'h0);
    chk("rst_pcp4", a_pcp4, 32'h0);
    chk("rst_req", {31'b0, a_req}, 32'd0);
    @(posedge clk); #2; rst_n = 1'b1;

    // Streaming fetch 0,4,8 with gnt=1, one-cycle latency
    @(negedge clk);
    chk("s_req0", {31'b0, a_req}, 32'd1);
    chk("s_addr0", a_addr, 32'h0);
    chk("b_addr0", b_addr, 32'hFFFF_FFFC);
    step(); @(negedge clk);
    chk("s_addr4", a_addr, 32'h4);
    chk("b_addr_wrap", b_addr, 32'h0);
    step(); @(negedge clk);
    chk("s_valid", {31'b0, a_valid}, 32'd1);
    chk("s_pcd0", a_pcd, 32'h0);
    chk("s_instr0", a_instr, 32'h0AB0_0000);
    chk("s_addr8", a_addr, 32'h8);
    chk("b_pcd", b_pcd, 32'hFFFF_FFFC);
    chk("b_pcp4", b_pcp4, 32'h0);
    chk("b_instr", b_instr, 32'hF54F_FFFC);

    // Stall three cycles while PC 8 returns
    step(); stall = 1'b1;
    @(negedge clk);
    chk("st_req", {31'b0, a_req}, 32'd0);
    chk("st_pcd", a_pcd, 32'h4);
    step(); @(negedge clk);
    chk("st_req2", {31'b0, a_req}, 32'd0);
    step();
    step(); stall = 1'b0;
    @(negedge clk);
    chk("st_rel_req", {31'b0, a_req}, 32'd0);
    step(); @(negedge clk);
    chk("st_pcd8", a_pcd, 32'h8);
    chk("st_instr8", a_instr, 32'h0AB0_0008);
    chk("st_addrC", a_addr, 32'hC);
    lat = 2;

    // Branch redirect while waiting -> kill
    step(); pcsrc = 2'b01; imm = 32'h100;
    @(negedge clk);
    chk("k_req", {31'b0, a_req}, 32'd0);
    step(); pcsrc = 2'b00;
    @(negedge clk);
    chk("k_req_kill", {31'b0, a_req}, 32'd0);
    chk("k_valid", {31'b0, a_valid}, 32'd0);
    step(); @(negedge clk);
    chk("k_addr100", a_addr, 32'h100);
    chk("k_valid2", {31'b0, a_valid}, 32'd0);

    // JALR redirect coinciding with rvalid
    step();
    step(); pcsrc = 2'b10; alu = 32'h203;
    @(negedge clk);
    chk("j_req", {31'b0, a_req}, 32'd0);
    step(); pcsrc = 2'b00; lat = 1;
    @(negedge clk);
    chk("j_addr202", a_addr, 32'h202);
    chk("j_valid", {31'b0, a_valid}, 32'd0);
    step(); @(negedge clk);
    chk("j_addr206", a_addr, 32'h206);

    // Flush with stall, then grant withheld
    step(); flush = 1'b1; stall = 1'b1;
    @(negedge clk);
    chk("f_pcd202", a_pcd, 32'h202);
    chk("f_pcp4", a_pcp4, 32'h206);
    step(); flush = 1'b0; stall = 1'b0; gnt = 1'b0;
    @(negedge clk);
    chk("f_valid", {31'b0, a_valid}, 32'd0);
    chk("f_instr", a_instr, 32'h0000_0013);
    step(); @(negedge clk);
    chk("f_pcd206", a_pcd, 32'h206);
    for (int i = 0; i < 5; i++) begin
      chk("g_req", {31'b0, a_req}, 32'd1);
      chk("g_addr", a_addr, 32'h20A);
      step();
      if (i < 4) @(negedge clk);
    end
    gnt = 1'b1;

    // Randomised soak, checked by the model
    for (int n = 0; n < 300; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      gnt   = ($urandom_range(0, 3) != 0);
      lat   = $urandom_range(1, 3);
      pcsrc = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      imm   = $urandom & 32'hFFFF_FFFC;
      alu   = $urandom;
      step();
    end
    pcsrc = 2'b00; stall = 1'b0; flush = 1'b0; gnt = 1'b1;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
